// File: rtl/fault_scan_reporter_if.sv
// Card-side bundle for one fault scan reporter: fault levels and the first-out clear
// go in; the serial frame, its status strobes and the first-out capture come out.
interface fault_scan_reporter_if #(
  parameter int N_FAULTS = 8
);
  logic [N_FAULTS-1:0] fault_in;
  logic                clear_req;
  logic                ser_tx;
  logic                tx_busy;
  logic                frame_done;
  logic                first_out_valid;
  logic [3:0]          first_out_idx;

  modport master (
    output fault_in, clear_req,
    input  ser_tx, tx_busy, frame_done, first_out_valid, first_out_idx
  );

  modport slave (
    input  fault_in, clear_req,
    output ser_tx, tx_busy, frame_done, first_out_valid, first_out_idx
  );
endinterface

// File: rtl/fault_scan_reporter.sv
// Reader end of one RPSC fault card: synchronises the latched fault lines, holds the
// first-out fault, and sends each change of fault status as a start/data/parity/stop frame.
module fault_scan_reporter #(
  parameter int N_FAULTS    = 8,
  parameter int BIT_DIV     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  fault_scan_reporter_if.slave    bus
);

  localparam int              DW       = $clog2(BIT_DIV);
  localparam logic [DW-1:0]   LAST_DIV = DW'(BIT_DIV - 1);
  localparam logic [3:0]      LAST_BIT = 4'(N_FAULTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Synchroniser
  logic [N_FAULTS-1:0] sync_q [SYNC_STAGES];
  logic [N_FAULTS-1:0] fault_s;

  // NOTE: sequential state is written with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.fault_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign fault_s = sync_q[SYNC_STAGES-1];

  // First-out capture
  function automatic logic [3:0] lowest_idx(input logic [N_FAULTS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = N_FAULTS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic       fo_valid_q;
  logic [3:0] fo_idx_q;

  // A clear in the same cycle as a pending capture wins; recapture follows next clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fo_valid_q <= 1'b0;
      fo_idx_q   <= '0;
    end else if (bus.clear_req) begin
      fo_valid_q <= 1'b0;
      fo_idx_q   <= '0;
    end else if (!fo_valid_q && (fault_s != '0)) begin
      fo_valid_q <= 1'b1;
      fo_idx_q   <= lowest_idx(fault_s);
    end
  end

  // Frame transmitter
  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [3:0]          bit_q, bit_d;
  logic [N_FAULTS-1:0] shreg_q, shreg_d;
  logic                parity_q, parity_d;
  logic [N_FAULTS-1:0] last_sent_q, last_sent_d;
  logic                ser_q, ser_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;

  // NOTE: the frame registers are ordinary control state, not a memory array, so they
  // are all reset; last_sent clearing to zero is what forces a fresh frame after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      last_sent_q <= '0;
      ser_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      last_sent_q <= last_sent_d;
      ser_q       <= ser_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bit_end = (div_q == LAST_DIV);

  // NOTE: every signal written below gets its hold value first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    last_sent_d = last_sent_q;

    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (fault_s != last_sent_q) state_d = LOAD;
      end
      LOAD: begin
        shreg_d     = fault_s;
        parity_d    = ^fault_s;
        last_sent_d = fault_s;
        bit_d       = '0;
        div_d       = '0;
        state_d     = START;
      end
      START: begin
        div_d = bit_end ? '0 : div_q + 1'b1;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        div_d = bit_end ? '0 : div_q + 1'b1;
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        div_d = bit_end ? '0 : div_q + 1'b1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        div_d = bit_end ? '0 : div_q + 1'b1;
        if (bit_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
  end

  // Line level and status are decoded from the next state so they leave a flop.
  always_comb begin
    ser_d = 1'b1;
    unique case (state_d)
      START:   ser_d = 1'b0;
      DATA:    ser_d = shreg_d[0];
      PARITY:  ser_d = parity_d;
      default: ser_d = 1'b1;
    endcase
    busy_d = (state_d == START) || (state_d == DATA) ||
             (state_d == PARITY) || (state_d == STOP);
    done_d = (state_d == STOP) && (div_d == LAST_DIV);
  end

  assign bus.ser_tx          = ser_q;
  assign bus.tx_busy         = busy_q;
  assign bus.frame_done      = done_q;
  assign bus.first_out_valid = fo_valid_q;
  assign bus.first_out_idx   = fo_idx_q;

endmodule
